// File: rtl/fifo_burst_rd_ctrl.sv
// Burst read controller on the read side of the 8-to-16-bit dual-clock FIFO.
// Drains BURST_LEN words per packet, framed with SOP/EOP and a checksum trailer.
module fifo_burst_rd_ctrl #(
    parameter int BURST_LEN = 32,
    parameter int GAP_CYC   = 4,
    parameter int USEDW_W   = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               enable,
    input  logic               rd_empty,
    input  logic               rd_full,
    input  logic [USEDW_W-1:0] rd_usedw,
    input  logic [15:0]        rd_data,
    output logic               rd_req,
    output logic               out_valid,
    output logic [15:0]        out_data,
    output logic               out_sop,
    output logic               out_eop,
    output logic [15:0]        burst_cnt,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_TAIL,
        S_GAP
    } state_t;

    localparam logic [7:0] LAST_RD  = 8'(BURST_LEN - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_rd_cnt;
    logic [7:0]  r_gap_cnt;
    logic        r_vld;
    logic        r_sop;
    logic        r_eop;
    logic [15:0] r_csum;
    logic [15:0] r_burst_cnt;

    logic w_thresh;
    logic w_rd_req;
    logic w_last_rd;
    logic w_start;

    assign w_thresh  = ((32'(rd_usedw) >= BURST_LEN) || rd_full) && !rd_empty;
    assign w_rd_req  = (r_state == S_READ) && !rd_empty;
    assign w_last_rd = w_rd_req && (r_rd_cnt == LAST_RD);
    assign w_start   = (r_state == S_WAIT) && (w_state_nxt == S_READ);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (enable)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!enable)
                    w_state_nxt = S_IDLE;
                else if (w_thresh)
                    w_state_nxt = S_READ;
            end
            S_READ: begin
                if (w_last_rd)
                    w_state_nxt = S_TAIL;
            end
            S_TAIL: begin
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                // first GAP cycle carries the trailer, then GAP_CYC quiet cycles
                if (r_gap_cnt == GAP_LAST)
                    w_state_nxt = S_WAIT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_rd_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_vld       <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_csum      <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vld   <= w_rd_req;
            r_sop   <= w_rd_req && (r_rd_cnt == 8'd0);
            r_eop   <= (r_state == S_TAIL);

            if (r_state == S_WAIT)
                r_rd_cnt <= '0;
            else if (w_rd_req)
                r_rd_cnt <= r_rd_cnt + 8'd1;

            if (r_state == S_GAP)
                r_gap_cnt <= r_gap_cnt + 8'd1;
            else
                r_gap_cnt <= '0;

            // rd_data lags rd_req by one cycle, so accumulate on the valid flag
            if (w_start)
                r_csum <= '0;
            else if (r_vld)
                r_csum <= r_csum + rd_data;

            if (r_state == S_TAIL)
                r_burst_cnt <= r_burst_cnt + 16'd1;
        end
    end

    always_comb begin
        rd_req    = w_rd_req;
        out_valid = r_vld || r_eop;
        out_sop   = r_sop;
        out_eop   = r_eop;
        burst_cnt = r_burst_cnt;
        busy      = (r_state == S_READ) || (r_state == S_TAIL) ||
                    (r_state == S_GAP);
        out_data  = 16'h0000;
        if (r_eop)
            out_data = r_csum;
        else if (r_vld)
            out_data = rd_data;
    end

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Directed bench for fifo_burst_rd_ctrl: vector table of bursts plus
// hand-written sequences for threshold, pause, enable drop, gap and reset.
module tb_fifo_burst_rd_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        enable  = 1'b0;
    logic        rd_empty;
    logic        rd_full;
    logic [7:0]  rd_usedw;
    logic [15:0] rd_data = 16'h0000;
    logic        rd_req;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] burst_cnt;
    logic        busy;

    logic        en1 = 1'b0;
    logic        rq1;
    logic        v1;
    logic [15:0] d1;
    logic        s1;
    logic        e1;
    logic [15:0] bc1;
    logic        b1;

    always #5 sys_clk = ~sys_clk;

    // FIFO read-side model, normal (non-show-ahead) mode
    logic [15:0] mem [0:1023];
    int          wp = 0;
    int          rp = 0;
    logic        force_empty = 1'b0;
    logic        force_full  = 1'b0;
    logic        ovr_en      = 1'b0;
    logic [7:0]  ovr_val     = 8'd0;

    assign rd_empty = (wp == rp) || force_empty;
    assign rd_full  = force_full;
    assign rd_usedw = ovr_en ? ovr_val :
                      (((wp - rp) > 255) ? 8'hFF : 8'(wp - rp));

    always @(posedge sys_clk) begin
        if (rd_req) begin
            rd_data <= mem[rp];
            rp      <= rp + 1;
        end
    end

    fifo_burst_rd_ctrl #(
        .BURST_LEN(32),
        .GAP_CYC  (4),
        .USEDW_W  (8)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .enable   (enable),
        .rd_empty (rd_empty),
        .rd_full  (rd_full),
        .rd_usedw (rd_usedw),
        .rd_data  (rd_data),
        .rd_req   (rd_req),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .burst_cnt(burst_cnt),
        .busy     (busy)
    );

    fifo_burst_rd_ctrl #(
        .BURST_LEN(1),
        .GAP_CYC  (0),
        .USEDW_W  (8)
    ) dut1 (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .enable   (en1),
        .rd_empty (1'b0),
        .rd_full  (1'b0),
        .rd_usedw (8'd5),
        .rd_data  (16'h1234),
        .rd_req   (rq1),
        .out_valid(v1),
        .out_data (d1),
        .out_sop  (s1),
        .out_eop  (e1),
        .burst_cnt(bc1),
        .busy     (b1)
    );

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        logic [15:0] csum;
        int          pause_at;
        int          drop_at;
        bit          hold31;
    } vec_t;

    vec_t vecs [4];
    int   total = 0;
    int   bad   = 0;
    int   exp_bursts = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] base, input logic [15:0] step,
                        input int n);
        for (int i = 0; i < n; i++) begin
            mem[wp] = base + step * 16'(i);
            wp++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rd_req"},    32'(rd_req),    0);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".out_data"},  32'(out_data),  0);
        chk({tag, ".out_sop"},   32'(out_sop),   0);
        chk({tag, ".out_eop"},   32'(out_eop),   0);
        chk({tag, ".burst_cnt"}, 32'(burst_cnt), 0);
        chk({tag, ".busy"},      32'(busy),      0);
    endtask

    // Watches one whole packet; returns on the negedge showing the trailer.
    task automatic run_burst(input string tag, input logic [15:0] base,
                             input logic [15:0] step, input logic [15:0] csum,
                             input int pause_at, input int drop_at,
                             input int exp_gaps);
        int          nreq = 0;
        int          nval = 0;
        int          gaps = 0;
        int          k = 0;
        int          plen = 0;
        int          pay_bad = 0;
        int          sop_bad = 0;
        int          both = 0;
        int          req_pause = 0;
        bit          done = 0;
        bit          started = 0;
        bit          paused = 0;
        logic [15:0] tr = 16'h0;
        logic [15:0] bc = 16'h0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge sys_clk);
            if (force_empty) begin
                plen--;
                if (plen == 0)
                    force_empty = 1'b0;
            end else if (pause_at != 0 && !paused && nreq == pause_at) begin
                force_empty = 1'b1;
                plen = 3;
                paused = 1;
            end
            if (drop_at != 0 && nreq == drop_at)
                enable = 1'b0;
            #1;
            if (rd_req) begin
                nreq++;
                if (force_empty)
                    req_pause++;
            end
            if (out_sop && out_eop)
                both++;
            if (out_valid) begin
                nval++;
                started = 1;
                if (out_eop) begin
                    tr = out_data;
                    bc = burst_cnt;
                    done = 1;
                end else begin
                    if (out_sop !== (k == 0))
                        sop_bad++;
                    if (out_data !== base + step * 16'(k))
                        pay_bad++;
                    k++;
                end
            end else if (started) begin
                gaps++;
            end
        end
        exp_bursts++;
        chk({tag, ".done"},      32'(done),      1);
        chk({tag, ".trailer"},   32'(tr),        32'(csum));
        chk({tag, ".nvalid"},    nval,           33);
        chk({tag, ".gaps"},      gaps,           exp_gaps);
        chk({tag, ".nreq"},      nreq,           32);
        chk({tag, ".sop"},       sop_bad,        0);
        chk({tag, ".payload"},   pay_bad,        0);
        chk({tag, ".sop_eop"},   both,           0);
        chk({tag, ".req_empty"}, req_pause,      0);
        chk({tag, ".burst_cnt"}, 32'(bc),        exp_bursts);
    endtask

    initial begin
        int n;
        int idle;
        int busy_idle;
        int outs_bad;
        bit hit;

        vecs[0] = '{16'h0001, 16'h0001, 16'h0210, 0,  0, 1'b1};
        vecs[1] = '{16'hFFFF, 16'h0000, 16'hFFE0, 0,  0, 1'b0};
        vecs[2] = '{16'h0001, 16'h0001, 16'h0210, 10, 0, 1'b0};
        vecs[3] = '{16'h1000, 16'h0100, 16'hF000, 0,  5, 1'b0};

        repeat (2) @(negedge sys_clk);
        #1;
        chk_reset("reset");
        @(negedge sys_clk);
        sys_rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            push(vecs[i].base, vecs[i].step, 32);
            enable = 1'b1;
            if (vecs[i].hold31) begin
                ovr_en  = 1'b1;
                ovr_val = 8'd31;
                n = 0;
                repeat (10) begin
                    @(negedge sys_clk);
                    #1;
                    if (rd_req)
                        n++;
                end
                chk("hold31.no_req", n, 0);
                chk("hold31.busy", 32'(busy), 0);
                ovr_en = 1'b0;
            end
            run_burst($sformatf("vec%0d", i), vecs[i].base, vecs[i].step,
                      vecs[i].csum, vecs[i].pause_at, vecs[i].drop_at,
                      (vecs[i].pause_at != 0) ? 3 : 0);
        end

        // enable was dropped mid-burst: no new burst even with data present
        push(16'h0003, 16'h0002, 32);
        push(16'hAAAA, 16'h0000, 10);
        push(16'h0000, 16'h0800, 32);
        ovr_en  = 1'b1;
        ovr_val = 8'd100;
        n = 0;
        repeat (30) begin
            @(negedge sys_clk);
            #1;
            if (rd_req)
                n++;
        end
        chk("drop.no_req", n, 0);
        chk("drop.busy", 32'(busy), 0);

        ovr_en     = 1'b0;
        force_full = 1'b1;
        enable     = 1'b1;
        run_burst("gapA", 16'h0003, 16'h0002, 16'h0440, 0, 0, 0);
        idle = 0;
        busy_idle = 0;
        outs_bad = 0;
        hit = 0;
        for (int j = 0; j < 20 && !hit; j++) begin
            @(negedge sys_clk);
            #1;
            if (rd_req) begin
                hit = 1;
            end else begin
                idle++;
                if (busy)
                    busy_idle++;
                if (out_valid || out_sop || out_eop || out_data != 16'h0)
                    outs_bad++;
            end
        end
        chk("gap.resume", 32'(hit), 1);
        chk("gap.idle", idle, 5);
        chk("gap.busy_idle", busy_idle, 4);
        chk("gap.outs", outs_bad, 0);

        n = 1;
        for (int j = 0; j < 40 && n < 10; j++) begin
            @(negedge sys_clk);
            #1;
            if (rd_req)
                n++;
        end
        chk("midrst.reads", n, 10);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        chk_reset("midrst");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        exp_bursts = 0;
        run_burst("postrst", 16'h0000, 16'h0800, 16'h8000, 0, 0, 0);

        en1 = 1'b1;
        hit = 0;
        for (int j = 0; j < 20 && !hit; j++) begin
            @(negedge sys_clk);
            #1;
            if (s1)
                hit = 1;
        end
        chk("bl1.sop_seen", 32'(hit), 1);
        chk("bl1.sop_data", 32'(d1), 32'h1234);
        @(negedge sys_clk);
        #1;
        chk("bl1.eop", 32'(e1), 1);
        chk("bl1.eop_valid", 32'(v1), 1);
        chk("bl1.trailer", 32'(d1), 32'h1234);
        chk("bl1.eop_nosop", 32'(s1), 0);
        chk("bl1.burst_cnt", 32'(bc1), 1);
        @(negedge sys_clk);
        #1;
        chk("bl1.wait_req", 32'(rq1), 0);
        chk("bl1.wait_valid", 32'(v1), 0);
        @(negedge sys_clk);
        #1;
        chk("bl1.read_req", 32'(rq1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
